// File: rtl/sle_cfg_loader_if.sv
// Mode-configuration bus between the serial config port and the SLE bank.
// The loader drives through the slave modport; the stream source uses master.
interface sle_cfg_loader_if #(
  parameter int N_CELLS = 8
);
  logic               start;
  logic               cfg_valid;
  logic               cfg_in;
  logic [N_CELLS-1:0] cfg_lat;
  logic [N_CELLS-1:0] cfg_sd;
  logic [N_CELLS-1:0] cfg_adn;
  logic               busy;
  logic               done;
  logic               err;

  modport master (
    output start, cfg_valid, cfg_in,
    input  cfg_lat, cfg_sd, cfg_adn, busy, done, err
  );

  modport slave (
    input  start, cfg_valid, cfg_in,
    output cfg_lat, cfg_sd, cfg_adn, busy, done, err
  );
endinterface

// File: rtl/sle_cfg_loader.sv
// Serial loader that collects a shadow SLE mode image and applies it in one cycle.
// Define SLE_CFG_PARITY_EN to append an even-parity bit to the stream and flag mismatches on err.
module sle_cfg_loader #(
  parameter int N_CELLS = 8
) (
  input logic              clk,
  input logic              rst,
  sle_cfg_loader_if.slave  bus
);

  localparam int L = 3 * N_CELLS;
`ifdef SLE_CFG_PARITY_EN
  localparam int SLEN = L + 1;
`else
  localparam int SLEN = L;
`endif
  localparam int CW = $clog2(SLEN + 1);
  localparam logic [CW-1:0] LAST_BIT  = CW'(SLEN - 1);
  localparam logic [CW-1:0] DATA_BITS = CW'(L);

  // Shadow reset mirrors the active outputs: lat fields 0, sd/adn fields 1.
  function automatic logic [L-1:0] shadow_init();
    logic [L-1:0] v;
    for (int k = 0; k < L; k++) v[k] = (k % 3 != 0);
    return v;
  endfunction

  localparam logic [L-1:0] SHADOW_RST = shadow_init();

  typedef enum logic [2:0] {IDLE, SHIFT, CHECK, APPLY, DONE} state_t;

  state_t             state;
  state_t             state_next;
  logic [CW-1:0]      cnt;
  logic [L-1:0]       shadow;
  logic [N_CELLS-1:0] sh_lat;
  logic [N_CELLS-1:0] sh_sd;
  logic [N_CELLS-1:0] sh_adn;
  logic               accept;

`ifdef SLE_CFG_PARITY_EN
  logic par_acc;
  logic err_q;
`endif

  assign accept = (state == SHIFT) && bus.cfg_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (bus.start) state_next = SHIFT;
      SHIFT: if (accept && cnt == LAST_BIT) state_next = CHECK;
`ifdef SLE_CFG_PARITY_EN
      CHECK: state_next = par_acc ? IDLE : APPLY;
`else
      CHECK: state_next = APPLY;
`endif
      APPLY: state_next = DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state == SHIFT) || (state == CHECK) || (state == APPLY);
    bus.done = (state == DONE);
  end

  // Bits enter at the top and shift down, so after L data bits bit k sits at shadow[k].
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      shadow <= SHADOW_RST;
    end else if (state == IDLE && bus.start) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= cnt + CW'(1);
      if (cnt < DATA_BITS) shadow <= {bus.cfg_in, shadow[L-1:1]};
    end
  end

  always_comb begin
    sh_lat = '0;
    sh_sd  = '0;
    sh_adn = '0;
    for (int i = 0; i < N_CELLS; i++) begin
      sh_lat[i] = shadow[3*i];
      sh_sd[i]  = shadow[3*i+1];
      sh_adn[i] = shadow[3*i+2];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.cfg_lat <= '0;
      bus.cfg_sd  <= '1;
      bus.cfg_adn <= '1;
    end else if (state == APPLY) begin
      bus.cfg_lat <= sh_lat;
      bus.cfg_sd  <= sh_sd;
      bus.cfg_adn <= sh_adn;
    end
  end

`ifdef SLE_CFG_PARITY_EN
  // par_acc folds in data and parity bits alike, so a clean even-parity stream leaves it at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_acc <= 1'b0;
      err_q   <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      par_acc <= 1'b0;
      err_q   <= 1'b0;
    end else if (accept) begin
      par_acc <= par_acc ^ bus.cfg_in;
    end else if (state == CHECK && par_acc) begin
      err_q <= 1'b1;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_sle_cfg_loader.sv
// Scoreboard bench for sle_cfg_loader with N_CELLS=4; also covers SLE_CFG_PARITY_EN when defined.
module tb_sle_cfg_loader;

  localparam int N = 4;
  localparam int L = 3 * N;
`ifdef SLE_CFG_PARITY_EN
  localparam int SLEN = L + 1;
`else
  localparam int SLEN = L;
`endif
  localparam int CLK_PERIOD = 10;
  localparam logic [L-1:0] BASIC = 12'b0000_1111_0101;

  typedef struct {
    logic [N-1:0] lat;
    logic [N-1:0] sd;
    logic [N-1:0] adn;
    int           cycles;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  exp_t         sb[$];
  int           vecCount  = 0;
  int           missCount = 0;
  int           doneCount = 0;
  longint       tStart    = 0;
  longint       edgeT     = 0;
  logic [N-1:0] curLat;
  logic [N-1:0] curSd;
  logic [N-1:0] curAdn;

  always #(CLK_PERIOD/2) clk = ~clk;

  sle_cfg_loader_if #(.N_CELLS(N)) bus ();

  sle_cfg_loader #(.N_CELLS(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic void decode(input logic [L-1:0] d, output logic [N-1:0] lat,
                                 output logic [N-1:0] sd, output logic [N-1:0] adn);
    for (int i = 0; i < N; i++) begin
      lat[i] = d[3*i];
      sd[i]  = d[3*i+1];
      adn[i] = d[3*i+2];
    end
  endfunction

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_lat"},  32'(bus.cfg_lat), 32'(4'h0));
    checkOutput({tag, "_sd"},   32'(bus.cfg_sd),  32'(4'hF));
    checkOutput({tag, "_adn"},  32'(bus.cfg_adn), 32'(4'hF));
    checkOutput({tag, "_busy"}, 32'(bus.busy),    32'(0));
    checkOutput({tag, "_done"}, 32'(bus.done),    32'(0));
    checkOutput({tag, "_err"},  32'(bus.err),     32'(0));
  endtask

  // Every done pulse must match the oldest pending expectation, including its latency.
  always begin : monitor
    exp_t e;
    @(posedge clk);
    edgeT = $time;
    #1;
    if (bus.done === 1'b1) begin
      doneCount++;
      checkOutput("done_expected", 32'(sb.size() > 0), 32'(1));
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput("done_lat",     32'(bus.cfg_lat), 32'(e.lat));
        checkOutput("done_sd",      32'(bus.cfg_sd),  32'(e.sd));
        checkOutput("done_adn",     32'(bus.cfg_adn), 32'(e.adn));
        checkOutput("done_latency", 32'((edgeT - tStart) / CLK_PERIOD + 1), 32'(e.cycles));
        checkOutput("done_busy",    32'(bus.busy), 32'(0));
        checkOutput("done_err",     32'(bus.err),  32'(0));
      end
    end
  end

  task automatic applyStimulus(input logic [L-1:0] data, input logic parBit,
                               input int stallAfter, input int stallLen, input bit pokeStart,
                               input int abortAfter, input bit extraBits, input bit expectApply);
    logic [N-1:0] eLat, eSd, eAdn;
    exp_t e;
    int   doneBefore;
    decode(data, eLat, eSd, eAdn);
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk);
    tStart = $time;
    #1;
    bus.start = 1'b0;
    checkOutput("busy_rise", 32'(bus.busy), 32'(1));
    if (abortAfter < 0 && expectApply) begin
      e.lat = eLat; e.sd = eSd; e.adn = eAdn;
      e.cycles = SLEN + 3 + stallLen;
      sb.push_back(e);
    end
    doneBefore = doneCount;
    for (int k = 0; k < SLEN; k++) begin
      if (k == abortAfter) begin
        bus.cfg_valid = 1'b0;
        rst = 1'b1;
        #2;
        checkResetValues("abort");
        rst = 1'b0;
        curLat = '0; curSd = '1; curAdn = '1;
        return;
      end
      if (k == stallAfter) begin
        bus.cfg_valid = 1'b0;
        repeat (stallLen) begin
          @(posedge clk); #1;
        end
        checkOutput("hold_lat", 32'(bus.cfg_lat), 32'(curLat));
        checkOutput("hold_sd",  32'(bus.cfg_sd),  32'(curSd));
        checkOutput("hold_adn", 32'(bus.cfg_adn), 32'(curAdn));
      end
      bus.cfg_valid = 1'b1;
      bus.cfg_in    = (k < L) ? data[k] : parBit;
      bus.start     = pokeStart && (k == 5);
      @(posedge clk); #1;
    end
    bus.cfg_valid = 1'b0;
    bus.start     = 1'b0;
    for (int c = 0; c < 12 && doneCount == doneBefore; c++) begin
      bus.cfg_valid = extraBits && (c < 3);
      bus.cfg_in    = 1'b1;
      @(posedge clk); #1;
    end
    bus.cfg_valid = 1'b0;
    @(posedge clk); #1;
    if (expectApply) begin
      checkOutput("done_once", 32'(doneCount - doneBefore), 32'(1));
      curLat = eLat; curSd = eSd; curAdn = eAdn;
      checkOutput("err_clear", 32'(bus.err), 32'(0));
    end else begin
      checkOutput("no_done", 32'(doneCount - doneBefore), 32'(0));
      checkOutput("err_set", 32'(bus.err), 32'(1));
    end
    checkOutput("busy_idle", 32'(bus.busy), 32'(0));
    checkOutput("post_lat",  32'(bus.cfg_lat), 32'(curLat));
    checkOutput("post_sd",   32'(bus.cfg_sd),  32'(curSd));
    checkOutput("post_adn",  32'(bus.cfg_adn), 32'(curAdn));
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [L-1:0] r;
    int           d;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_in = 1'b0;
    #12;
    checkResetValues("reset");
    rst = 1'b0;
    curLat = '0; curSd = '1; curAdn = '1;

    $display("[TB] basic load");
    applyStimulus(BASIC, ^BASIC, -1, 0, 1'b0, -1, 1'b0, 1'b1);
    checkOutput("basic_lat", 32'(bus.cfg_lat), 32'(4'b0101));
    checkOutput("basic_sd",  32'(bus.cfg_sd),  32'(4'b0110));
    checkOutput("basic_adn", 32'(bus.cfg_adn), 32'(4'b0011));

    $display("[TB] random load then stalled basic load");
    r = L'($urandom);
    applyStimulus(r, ^r, -1, 0, 1'b0, -1, 1'b0, 1'b1);
    applyStimulus(BASIC, ^BASIC, 6, 5, 1'b0, -1, 1'b0, 1'b1);

    $display("[TB] busy protection");
    r = L'($urandom);
    applyStimulus(r, ^r, -1, 0, 1'b1, -1, 1'b1, 1'b1);

    $display("[TB] mid-load reset");
    applyStimulus(BASIC, ^BASIC, -1, 0, 1'b0, 7, 1'b0, 1'b1);
    d = doneCount;
    repeat (20) @(posedge clk);
    #1;
    checkOutput("abort_no_done", 32'(doneCount - d), 32'(0));
    checkResetValues("abort_hold");
    r = L'($urandom);
    applyStimulus(r, ^r, -1, 0, 1'b0, -1, 1'b0, 1'b1);

`ifdef SLE_CFG_PARITY_EN
    $display("[TB] parity checks");
    applyStimulus(BASIC, 1'b1, -1, 0, 1'b0, -1, 1'b0, 1'b0);
    applyStimulus(BASIC, 1'b0, -1, 0, 1'b0, -1, 1'b0, 1'b1);
`endif

    repeat (3) @(posedge clk);
    #1;
    checkOutput("sb_empty", 32'(sb.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
